// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer producing the design-wide system reset.
// Runs on the free-running PLL reference clock; every output is a registered decode of the state.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_i,
  input  logic       soft_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lol_count,
  output logic [2:0] state_o
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CW        = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int RW        = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  logic [1:0]    sync_r;
  logic          locked_s;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic [RW-1:0] retry_r;
  logic [RW-1:0] retry_nxt_s;
  logic          lol_inc_s;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], locked_i};
    end
  end

  assign locked_s = sync_r[1];

  // Next-state, retry and shared-counter logic; soft_req outranks lock and timeout
  always_comb begin
    state_nxt_s = state_r;
    retry_nxt_s = retry_r;
    lol_inc_s   = 1'b0;
    case (state_r)
      ST_RESET_PLL: begin
        if (cnt_r == RST_LAST) begin
          state_nxt_s = ST_WAIT_LOCK;
        end else begin
          state_nxt_s = ST_RESET_PLL;
        end
      end
      ST_WAIT_LOCK: begin
        if (soft_req) begin
          state_nxt_s = ST_RESET_PLL;
          retry_nxt_s = {RW{1'b0}};
        end else if (locked_s) begin
          state_nxt_s = ST_STABLE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          if (retry_r == RETRY_LIMIT) begin
            state_nxt_s = ST_FAIL;
          end else begin
            state_nxt_s = ST_RESET_PLL;
            retry_nxt_s = retry_r + RW'(1);
          end
        end else begin
          state_nxt_s = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (soft_req) begin
          state_nxt_s = ST_RESET_PLL;
          retry_nxt_s = {RW{1'b0}};
        end else if (!locked_s) begin
          state_nxt_s = ST_WAIT_LOCK;
        end else if (cnt_r == STABLE_LAST) begin
          state_nxt_s = ST_RUN;
          retry_nxt_s = {RW{1'b0}};
        end else begin
          state_nxt_s = ST_STABLE;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_nxt_s = ST_RESET_PLL;
          lol_inc_s   = 1'b1;
        end else if (soft_req) begin
          state_nxt_s = ST_RESET_PLL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FAIL: begin
        if (soft_req) begin
          state_nxt_s = ST_RESET_PLL;
          retry_nxt_s = {RW{1'b0}};
        end else begin
          state_nxt_s = ST_FAIL;
        end
      end
      default: begin
        state_nxt_s = ST_RESET_PLL;
        retry_nxt_s = {RW{1'b0}};
      end
    endcase

    // cnt only runs in the timed states, so it can never wrap while parked in RUN or FAIL
    cnt_nxt_s = cnt_r;
    if (state_nxt_s != state_r) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if ((state_r == ST_RESET_PLL) || (state_r == ST_WAIT_LOCK) || (state_r == ST_STABLE)) begin
      cnt_nxt_s = cnt_r + CW'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State, counters and outputs registered from the next state so outputs track state exactly
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r   <= ST_RESET_PLL;
      cnt_r     <= {CW{1'b0}};
      retry_r   <= {RW{1'b0}};
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      lol_count <= 8'd0;
      state_o   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      retry_r <= retry_nxt_s;
      pll_rst <= (state_nxt_s == ST_RESET_PLL) || (state_nxt_s == ST_FAIL);
      sys_rst <= (state_nxt_s != ST_RUN);
      ready   <= (state_nxt_s == ST_RUN);
      fail    <= (state_nxt_s == ST_FAIL);
      state_o <= state_nxt_s;
      if (lol_inc_s && (lol_count != 8'hFF)) begin
        lol_count <= lol_count + 8'd1;
      end else begin
        lol_count <= lol_count;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with small timing parameters
// (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2).
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked_i;
  logic       soft_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [7:0] lol_count;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_lol = 0;

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .locked_i (locked_i),
    .soft_req (soft_req),
    .pll_rst  (pll_rst),
    .sys_rst  (sys_rst),
    .ready    (ready),
    .fail     (fail),
    .lol_count(lol_count),
    .state_o  (state_o)
  );

  always #5 refclk = ~refclk;

  // one rising edge, then land on the following falling edge
  task automatic step();
    @(negedge refclk);
  endtask

  // starts right after the edge that entered RESET_PLL (cnt=0) with locked_i low; ends in RUN
  task automatic bringup();
    repeat (3) step();
    n_cmp++;
    if (pll_rst !== 1'b1 || state_o !== 3'd0) begin
      n_bad++;
      $display("FAIL bringup_rst_hold: pll_rst=%b state_o=%0d, expected 1/0", pll_rst, state_o);
    end
    step();
    n_cmp++;
    if (pll_rst !== 1'b0 || state_o !== 3'd1) begin
      n_bad++;
      $display("FAIL bringup_rst_fall: pll_rst=%b state_o=%0d, expected 0/1", pll_rst, state_o);
    end
    repeat (5) step();
    locked_i = 1'b1;
    repeat (2) step();
    n_cmp++;
    if (state_o !== 3'd1) begin
      n_bad++;
      $display("FAIL bringup_sync_delay: state_o=%0d, expected 1", state_o);
    end
    step();
    n_cmp++;
    if (state_o !== 3'd2) begin
      n_bad++;
      $display("FAIL bringup_stable: state_o=%0d, expected 2", state_o);
    end
    repeat (7) step();
    n_cmp++;
    if (sys_rst !== 1'b1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bringup_early_release: sys_rst=%b ready=%b, expected 1/0", sys_rst, ready);
    end
    step();
    n_cmp++;
    if (sys_rst !== 1'b0 || ready !== 1'b1 || state_o !== 3'd3 || pll_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL bringup_run: sys_rst=%b ready=%b state_o=%0d pll_rst=%b, expected 0/1/3/0",
               sys_rst, ready, state_o, pll_rst);
    end
  endtask

  // starts right after entering RESET_PLL with a fresh retry budget; ends in FAIL
  task automatic no_lock_run();
    for (int k = 1; k <= 72; k++) begin
      logic       exp_p;
      logic [2:0] exp_st;
      step();
      exp_p  = ((k % 24) < 4) ? 1'b1 : 1'b0;
      exp_st = (k == 72) ? 3'd4 : (exp_p ? 3'd0 : 3'd1);
      n_cmp++;
      if (pll_rst !== exp_p || state_o !== exp_st || sys_rst !== 1'b1 || fail !== (k == 72)) begin
        n_bad++;
        $display("FAIL no_lock_edge%0d: pll_rst=%b state_o=%0d sys_rst=%b fail=%b, expected %b/%0d/1/%b",
                 k, pll_rst, state_o, sys_rst, fail, exp_p, exp_st, (k == 72));
      end
    end
    repeat (5) step();
    n_cmp++;
    if (state_o !== 3'd4 || fail !== 1'b1 || pll_rst !== 1'b1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fail_hold: state_o=%0d fail=%b pll_rst=%b ready=%b, expected 4/1/1/0",
               state_o, fail, pll_rst, ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    locked_i = 1'b0;
    soft_req = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0 || fail !== 1'b0 ||
        lol_count !== 8'd0 || state_o !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_values: pll_rst=%b sys_rst=%b ready=%b fail=%b lol=%0d state_o=%0d, expected 1/1/0/0/0/0",
               pll_rst, sys_rst, ready, fail, lol_count, state_o);
    end
  endtask

  task automatic test_bringup();
    rst = 1'b0;
    bringup();
  endtask

  task automatic test_loss_of_lock(input int n);
    for (int i = 0; i < n; i++) begin
      locked_i = 1'b0;
      repeat (2) step();
      n_cmp++;
      if (state_o !== 3'd3 || sys_rst !== 1'b0) begin
        n_bad++;
        $display("FAIL lol_early: state_o=%0d sys_rst=%b, expected 3/0", state_o, sys_rst);
      end
      step();
      exp_lol = (exp_lol == 255) ? 255 : exp_lol + 1;
      n_cmp++;
      if (sys_rst !== 1'b1 || pll_rst !== 1'b1 || state_o !== 3'd0 || lol_count !== 8'(exp_lol)) begin
        n_bad++;
        $display("FAIL lol_react: sys_rst=%b pll_rst=%b state_o=%0d lol=%0d, expected 1/1/0/%0d",
                 sys_rst, pll_rst, state_o, lol_count, exp_lol);
      end
      bringup();
    end
  endtask

  task automatic test_soft_in_run();
    locked_i = 1'b0;
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    n_cmp++;
    if (state_o !== 3'd0 || pll_rst !== 1'b1 || sys_rst !== 1'b1 || lol_count !== 8'(exp_lol)) begin
      n_bad++;
      $display("FAIL soft_run: state_o=%0d pll_rst=%b sys_rst=%b lol=%0d, expected 0/1/1/%0d",
               state_o, pll_rst, sys_rst, lol_count, exp_lol);
    end
  endtask

  // soft_req must be ignored in RESET_PLL; lock then drops mid-qualification
  task automatic test_stable_glitch();
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (state_o !== 3'd1 || pll_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL soft_ignored_in_reset: state_o=%0d pll_rst=%b, expected 1/0", state_o, pll_rst);
    end
    locked_i = 1'b1;
    repeat (8) step();
    n_cmp++;
    if (state_o !== 3'd2) begin
      n_bad++;
      $display("FAIL glitch_pre: state_o=%0d, expected 2", state_o);
    end
    locked_i = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      logic [2:0] exp_st;
      if (e == 4) locked_i = 1'b1;
      step();
      exp_st = (e <= 2) ? 3'd2 : (e <= 5) ? 3'd1 : (e <= 13) ? 3'd2 : 3'd3;
      n_cmp++;
      if (state_o !== exp_st || pll_rst !== 1'b0 || sys_rst !== (e != 14)) begin
        n_bad++;
        $display("FAIL glitch_edge%0d: state_o=%0d pll_rst=%b sys_rst=%b, expected %0d/0/%b",
                 e, state_o, pll_rst, sys_rst, exp_st, (e != 14));
      end
    end
  endtask

  task automatic test_reset_mid();
    n_cmp++;
    if (lol_count !== 8'd2 || state_o !== 3'd3) begin
      n_bad++;
      $display("FAIL reset_mid_pre: lol=%0d state_o=%0d, expected 2/3", lol_count, state_o);
    end
    rst = 1'b1;
    locked_i = 1'b0;
    step();
    rst = 1'b0;
    exp_lol = 0;
    n_cmp++;
    if (pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0 || fail !== 1'b0 ||
        lol_count !== 8'd0 || state_o !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_mid: pll_rst=%b sys_rst=%b ready=%b fail=%b lol=%0d state_o=%0d, expected 1/1/0/0/0/0",
               pll_rst, sys_rst, ready, fail, lol_count, state_o);
    end
    bringup();
  endtask

  task automatic test_soft_with_lol();
    locked_i = 1'b0;
    repeat (2) step();
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    exp_lol = exp_lol + 1;
    n_cmp++;
    if (state_o !== 3'd0 || lol_count !== 8'(exp_lol)) begin
      n_bad++;
      $display("FAIL soft_with_lol: state_o=%0d lol=%0d, expected 0/%0d", state_o, lol_count, exp_lol);
    end
    bringup();
  endtask

  task automatic test_no_lock();
    test_soft_in_run();
    no_lock_run();
  endtask

  task automatic test_soft_in_fail();
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    n_cmp++;
    if (fail !== 1'b0 || state_o !== 3'd0 || pll_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL soft_fail: fail=%b state_o=%0d pll_rst=%b, expected 0/0/1", fail, state_o, pll_rst);
    end
    no_lock_run();
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    bringup();
  endtask

  task automatic test_lol_saturate();
    test_loss_of_lock(300);
    n_cmp++;
    if (lol_count !== 8'd255) begin
      n_bad++;
      $display("FAIL lol_saturate: lol=%0d, expected 255", lol_count);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_bringup();
    test_loss_of_lock(2);
    test_soft_in_run();
    test_stable_glitch();
    test_reset_mid();
    test_soft_with_lol();
    test_no_lock();
    test_soft_in_fail();
    test_lol_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences the system PLL's reset and lock qualification, and produces the design-wide system reset. It runs on the free-running PLL reference clock. It drives the PLL `rst` input and samples the PLL `locked` output. It releases `sys_rst` only after lock has been stable for a programmed time, and it re-runs the sequence on loss of lock, lock timeout or software request.

## Interface
- `RST_CYCLES`, 16: width in cycles of each PLL reset pulse; must be ≥2.
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock after the PLL reset is released.
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before `sys_rst` is released.
- `MAX_RETRIES`, 3: timeouts tolerated before entering FAIL.
- `refclk` in 1: reference clock; the only clock in the block.
- `rst` in 1: synchronous, active-high reset.
- `locked_i` in 1: PLL `locked`; asynchronous to `refclk`.
- `soft_req` in 1: single-cycle software request to restart the sequence.
- `pll_rst` out 1: drives the PLL `rst`.
- `sys_rst` out 1: active-high system reset.
- `ready` out 1: 1 only in RUN.
- `fail` out 1: 1 only in FAIL.
- `lol_count` out 8: number of loss-of-lock events seen in RUN; saturates at 255.
- `state_o` out 3: encoding RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

## Operation
- `locked_i` passes through a 2-flop synchronizer to give `locked_s`. All decisions use `locked_s`.
- There is one shared counter `cnt`, cleared on every state change, and a retry counter `retry`.
- All outputs are flops. Each output equals a decode of the current state: `pll_rst`=1 in RESET_PLL and FAIL; `sys_rst`=0 only in RUN.
- **RESET_PLL:**
  - `cnt` increments each cycle.
  - At `cnt==RST_CYCLES-1`, go to WAIT_LOCK.
  - `soft_req` is ignored.
- **WAIT_LOCK:**
  - If `locked_s`=1, go to STABLE.
  - Else, at `cnt==LOCK_TIMEOUT-1`: if `retry==MAX_RETRIES`, go to FAIL; otherwise `retry`++ and go to RESET_PLL.
  - If lock and timeout occur in the same cycle, lock wins.
- **STABLE:**
  - If `locked_s`=0, go to WAIT_LOCK. `retry` is unchanged and the timeout restarts.
  - At `cnt==STABLE_CYCLES-1` with `locked_s`=1, go to RUN and clear `retry`.
- **RUN:**
  - If `locked_s`=0, `lol_count`++ (saturating) and go to RESET_PLL.
  - Else if `soft_req`, go to RESET_PLL.
  - If both occur in the same cycle, the count increments once.
- **FAIL:** hold until `soft_req` or `rst`. On `soft_req`, go to RESET_PLL and clear `retry`.
- `soft_req` in WAIT_LOCK or STABLE: go to RESET_PLL and clear `retry`. `soft_req` takes priority over lock and timeout.
- Reset values: state RESET_PLL, `cnt`=0, `retry`=0, synchronizer flops 0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `lol_count`=0, `state_o`=0.
- `rst` asserted in any state, including mid-RUN, returns to the reset values on the next edge. `lol_count` is cleared.
- Counter width is `$clog2` of the largest of `RST_CYCLES`, `LOCK_TIMEOUT` and `STABLE_CYCLES`. Compares are exact-equal; `cnt` never wraps.

## Timing
- After `rst` is released, `pll_rst` stays 1 for exactly `RST_CYCLES` cycles, then falls.
- `locked_i` to `locked_s`: 2 cycles.
- `locked_i` rise to `sys_rst` fall (when already in WAIT_LOCK): 2 + 1 + `STABLE_CYCLES` edges.
- `locked_i` fall in RUN to `sys_rst` rise: 3 edges (2 synchronizer + 1 state register). `pll_rst` rises on the same edge.
- One timeout attempt takes `RST_CYCLES` + `LOCK_TIMEOUT` cycles. FAIL is entered after (`MAX_RETRIES`+1) attempts.
- `soft_req` to a state change: 1 edge. The outputs change on that same edge.
- No glitches: every output comes directly from a flop.

## Test plan
All scenarios use `RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `MAX_RETRIES`=2.

1. **Normal bring-up.** Release `rst`, then raise `locked_i` 5 cycles after `pll_rst` falls → `pll_rst` high for exactly 4 cycles; `sys_rst` falls 11 edges after the `locked_i` rise; `ready`=1, `state_o`=3.
2. **Lock never arrives.** Hold `locked_i`=0 → exactly 3 `pll_rst` pulses of 4 cycles each, spaced 24 cycles apart; `fail`=1 and `state_o`=4 at cycle 72; `sys_rst` stays 1 throughout.
3. **Lock glitch in STABLE.** Drop `locked_i` for 3 cycles at STABLE `cnt`=5 → return to WAIT_LOCK with no `pll_rst` pulse; the stable count restarts from 0; `sys_rst` is released 8 cycles after re-qualification.
4. **Loss of lock in RUN.** Drop `locked_i` → `sys_rst`=1 and `pll_rst`=1 3 edges later; `lol_count`=1; full re-bring-up succeeds. Repeat 300 times → `lol_count` saturates at 255.
5. **Software restart.** `soft_req` in FAIL → `fail`=0, `state_o`=0, and the retry budget is reset to 3 attempts. `soft_req` in RUN → RESET_PLL next edge, `lol_count` unchanged. `soft_req` in the same cycle as a lock loss → `lol_count` +1.
6. **Reset mid-operation.** Assert `rst` for 1 cycle in RUN with `lol_count`=2 → next edge all outputs at reset values (`pll_rst`=1, `sys_rst`=1, `lol_count`=0); the sequence then restarts identically to scenario 1.
